// File: rtl/jtkicker_obj_pkg.sv
// Shared definitions for the Kicker object scan block: scan states,
// sprite height and the queued sprite record layout.
package jtkicker_obj_pkg;

    localparam int OBJH = 16;

    typedef enum logic [2:0] {
        IDLE,
        RDY,
        W1,
        CHK,
        W2,
        GET,
        END
    } scan_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] attr;
        logic [7:0] xpos;
        logic [3:0] v;
    } obj_entry_t;

    localparam int ENTRY_W = $bits(obj_entry_t);

endpackage

// File: rtl/jtkicker_objscan_fifo.sv
// Small synchronous sprite queue between the table scan and the draw issue logic.
// All updates are qualified by cen; flush empties the queue and wins over push/pop.
module jtkicker_objscan_fifo
    import jtkicker_obj_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = cen && !flush && push && !full;
    assign do_pop  = cen && !flush && pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (cen) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/jtkicker_objscan.sv
// Per-line sprite scheduler: scans the object table on hinit, queues sprites
// covering the current line and hands them one at a time to the draw engine.
module jtkicker_objscan
    import jtkicker_obj_pkg::*;
#(
    parameter int NOBJ   = 32,
    parameter int SAW    = 6,
    parameter int QDEPTH = 4,
    parameter int MAXOBJ = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           hinit,
    input  logic [7:0]     vrender,
    input  logic           flip,
    output logic [SAW-1:0] scan_addr,
    input  logic [7:0]     hi_dout,
    input  logic [7:0]     low_dout,
    output logic           dr_start,
    input  logic           dr_busy,
    output logic [7:0]     dr_code,
    output logic [7:0]     dr_attr,
    output logic [7:0]     dr_xpos,
    output logic [3:0]     dr_v,
    output logic           done,
    output logic           ovf
);
    localparam int IW = SAW - 1;
    localparam int CW = $clog2(MAXOBJ + 1);

    scan_state_t        st;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      cnt;
    logic               hinit_l;
    logic               hinit_go;
    logic [7:0]         attr_l;
    logic [3:0]         v_l;
    logic [7:0]         ydiff;
    logic               inzone;
    logic               last;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    obj_entry_t         push_e;
    obj_entry_t         head_e;
    logic [ENTRY_W-1:0] head_raw;

    // Modulo-256 difference makes sprites straddling line 0 wrap naturally.
    assign ydiff    = vrender - hi_dout;
    assign inzone   = ydiff < 8'(OBJH);
    assign last     = (idx == IW'(NOBJ - 1));
    assign hinit_go = hinit | hinit_l;
    assign push     = (st == GET) && !full && !hinit_go;
    assign pop      = dr_start && dr_busy && !hinit_go;
    assign head_e   = obj_entry_t'(head_raw);

    always_comb begin
        push_e      = '0;
        push_e.code = hi_dout;
        push_e.attr = attr_l;
        push_e.xpos = low_dout;
        push_e.v    = v_l;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     hinit_l <= 1'b0;
        else if (cen)   hinit_l <= 1'b0;
        else if (hinit) hinit_l <= 1'b1;
    end

    jtkicker_objscan_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .flush (hinit_go),
        .push  (push),
        .din   (push_e),
        .pop   (pop),
        .dout  (head_raw),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            done      <= 1'b1;
            scan_addr <= '0;
            attr_l    <= '0;
            v_l       <= '0;
        end else if (cen) begin
            if (hinit_go) begin
                st        <= RDY;
                idx       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
                done      <= 1'b0;
                scan_addr <= '0;
            end else begin
                case (st)
                    IDLE, END: ;
                    RDY: begin
                        scan_addr <= {idx, 1'b0};
                        st        <= W1;
                    end
                    W1: st <= CHK;
                    CHK: begin
                        if (inzone) begin
                            attr_l    <= low_dout;
                            v_l       <= ydiff[3:0] ^ {4{flip}};
                            scan_addr <= {idx, 1'b1};
                            st        <= W2;
                        end else if (last) begin
                            st   <= END;
                            done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            st  <= RDY;
                        end
                    end
                    W2: st <= GET;
                    GET: begin
                        // A full queue stalls here; RAM still holds the code word.
                        if (!full) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CW'(MAXOBJ - 1)) begin
                                ovf  <= 1'b1;
                                done <= 1'b1;
                                st   <= END;
                            end else if (last) begin
                                st   <= END;
                                done <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                                st  <= RDY;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    // Issue side: the head stays queued until the draw engine acknowledges with busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_start <= 1'b0;
            dr_code  <= '0;
            dr_attr  <= '0;
            dr_xpos  <= '0;
            dr_v     <= '0;
        end else if (cen) begin
            if (hinit_go) begin
                dr_start <= 1'b0;
            end else if (!dr_start) begin
                if (!empty && !dr_busy) begin
                    dr_code  <= head_e.code;
                    dr_attr  <= head_e.attr;
                    dr_xpos  <= head_e.xpos;
                    dr_v     <= head_e.v;
                    dr_start <= 1'b1;
                end
            end else if (dr_busy) begin
                dr_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtkicker_objscan.sv
// Directed bench for jtkicker_objscan: table model, draw engine model and
// request checker compared against a per-line list of expected sprites.
module tb_jtkicker_objscan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       hinit;
    logic [7:0] vrender;
    logic       flip;
    logic [5:0] scan_addr;
    logic [7:0] hi_dout = 8'd0;
    logic [7:0] low_dout = 8'd0;
    logic       dr_start;
    logic       dr_busy;
    logic [7:0] dr_code, dr_attr, dr_xpos;
    logic [3:0] dr_v;
    logic       done, ovf;

    always #5 clk = ~clk;

    jtkicker_objscan dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .hinit(hinit), .vrender(vrender),
        .flip(flip), .scan_addr(scan_addr), .hi_dout(hi_dout), .low_dout(low_dout),
        .dr_start(dr_start), .dr_busy(dr_busy), .dr_code(dr_code), .dr_attr(dr_attr),
        .dr_xpos(dr_xpos), .dr_v(dr_v), .done(done), .ovf(ovf)
    );

    // Object table: ypos/code in the high RAM, attr/xpos in the low RAM.
    logic [7:0] ty [32];
    logic [7:0] ta [32];
    logic [7:0] tc [32];
    logic [7:0] tx [32];

    always @(posedge clk) begin
        hi_dout  <= scan_addr[0] ? tc[scan_addr[5:1]] : ty[scan_addr[5:1]];
        low_dout <= scan_addr[0] ? tx[scan_addr[5:1]] : ta[scan_addr[5:1]];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected sprite list for a line, straight from the scheduling rules.
    logic [7:0] exp_code [16];
    logic [7:0] exp_attr [16];
    logic [7:0] exp_x    [16];
    logic [3:0] exp_v    [16];
    int         exp_n;
    int         exp_ovf;
    int         line_id = 0;

    task automatic build_exp(input logic [7:0] vr, input logic fl);
        logic [7:0] d;
        exp_n = 0;
        for (int i = 0; i < 32; i++) begin
            d = vr - ty[i];
            if (exp_n < 16 && d < 16) begin
                exp_code[exp_n] = tc[i];
                exp_attr[exp_n] = ta[i];
                exp_x[exp_n]    = tx[i];
                exp_v[exp_n]    = fl ? ~d[3:0] : d[3:0];
                exp_n++;
            end
        end
        exp_ovf = (exp_n == 16) ? 1 : 0;
    endtask

    // Request monitor: every new request must be the next expected sprite and
    // the request fields must stay put while dr_start is held.
    int         rx_k = 0;
    int         seen_line = 0;
    logic [7:0] rx_code [32];
    logic [7:0] rx_attr [32];
    logic [7:0] rx_x    [32];
    logic [3:0] rx_v    [32];

    initial begin
        logic        prev_start;
        logic [27:0] snap;
        prev_start = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (line_id != seen_line) begin
                rx_k = 0;
                seen_line = line_id;
            end
            if (!rst_n) begin
                prev_start = 1'b0;
            end else begin
                if (dr_start && !prev_start) begin
                    if (rx_k < exp_n) begin
                        check("req_code", int'(dr_code), int'(exp_code[rx_k]));
                        check("req_attr", int'(dr_attr), int'(exp_attr[rx_k]));
                        check("req_xpos", int'(dr_x_w()), int'(exp_x[rx_k]));
                        check("req_v",    int'(dr_v),    int'(exp_v[rx_k]));
                    end else begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_request: got request #%0d code 0x%0h, expected only %0d", rx_k, dr_code, exp_n);
                    end
                    if (rx_k < 32) begin
                        rx_code[rx_k] = dr_code;
                        rx_attr[rx_k] = dr_attr;
                        rx_x[rx_k]    = dr_xpos;
                        rx_v[rx_k]    = dr_v;
                    end
                    rx_k++;
                    snap = {dr_code, dr_attr, dr_xpos, dr_v};
                end else if (dr_start && prev_start) begin
                    check("req_stable", int'({dr_code, dr_attr, dr_xpos, dr_v}), int'(snap));
                end
                prev_start = dr_start;
            end
        end
    end

    function automatic logic [7:0] dr_x_w();
        return dr_xpos;
    endfunction

    // cen on every other clk; draw engine raises busy on the first cen after
    // it sees start, holds it for blen cen, then drops it.
    logic force_busy = 1'b0;
    int   blen = 2;

    initial begin
        int   ebusy;
        logic cen_ph;
        logic expect_fall;
        ebusy = 0;
        cen_ph = 1'b0;
        expect_fall = 1'b0;
        cen = 1'b0;
        dr_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (expect_fall && rst_n) check("start_fall", int'(dr_start), 0);
            expect_fall = 1'b0;
            cen_ph = !cen_ph;
            cen = cen_ph;
            if (cen) begin
                if (force_busy) begin
                    dr_busy = 1'b1;
                    ebusy = 0;
                end else if (ebusy > 0) begin
                    ebusy--;
                    dr_busy = (ebusy != 0);
                end else if (dr_start) begin
                    dr_busy = 1'b1;
                    ebusy = blen;
                    expect_fall = 1'b1;
                end else begin
                    dr_busy = 1'b0;
                end
            end
        end
    end

    task automatic pulse_hinit();
        @(negedge clk);
        hinit = 1'b1;
        @(negedge clk);
        hinit = 1'b0;
    endtask

    task automatic start_line(input logic [7:0] vr, input logic fl);
        vrender = vr;
        flip = fl;
        build_exp(vr, fl);
        line_id++;
        pulse_hinit();
        @(negedge clk);
        check("restart_addr", int'(scan_addr), 0);
        check("done_clear", int'(done), 0);
    endtask

    task automatic finish_line();
        int t;
        t = 0;
        while (!done && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", int'(done), 1);
        t = 0;
        while (rx_k < exp_n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (80) @(negedge clk);
        check("req_count", rx_k, exp_n);
        check("ovf", int'(ovf), exp_ovf);
        check("done_end", int'(done), 1);
    endtask

    task automatic clear_table(input logic [7:0] y);
        for (int i = 0; i < 32; i++) begin
            ty[i] = y;
            ta[i] = 8'(i);
            tc[i] = 8'(i + 8'h20);
            tx[i] = 8'(3 * i);
        end
    endtask

    task automatic full_table();
        for (int i = 0; i < 32; i++) begin
            ty[i] = 8'h60 - 8'(i % 16);
            ta[i] = 8'(i);
            tc[i] = 8'(8'h40 + i);
            tx[i] = 8'(2 * i);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_scan_addr", int'(scan_addr), 0);
        check("rst_dr_start", int'(dr_start), 0);
        check("rst_dr_code", int'(dr_code), 0);
        check("rst_dr_attr", int'(dr_attr), 0);
        check("rst_dr_xpos", int'(dr_xpos), 0);
        check("rst_dr_v", int'(dr_v), 0);
        check("rst_done", int'(done), 1);
        check("rst_ovf", int'(ovf), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        hinit = 1'b0;
        vrender = 8'd0;
        flip = 1'b0;
        exp_n = 0;
        exp_ovf = 0;
        clear_table(8'h00);
        repeat (4) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("idle_no_req", rx_k, 0);

        // Single sprite, unflipped then flipped.
        clear_table(8'h00);
        ty[3] = 8'h3A; ta[3] = 8'hC5; tc[3] = 8'h12; tx[3] = 8'h80;
        start_line(8'h40, 1'b0);
        finish_line();
        check("one_code", int'(rx_code[0]), 'h12);
        check("one_attr", int'(rx_attr[0]), 'hC5);
        check("one_xpos", int'(rx_x[0]), 'h80);
        check("one_v", int'(rx_v[0]), 6);
        start_line(8'h40, 1'b1);
        finish_line();
        check("flip_v", int'(rx_v[0]), 9);

        // Wrap-around acceptance and the ydiff=16 rejection edge.
        clear_table(8'h80);
        ty[5] = 8'hF8; tc[5] = 8'h55;
        start_line(8'h03, 1'b0);
        finish_line();
        check("wrap_v", int'(rx_v[0]), 'h0B);
        check("wrap_code", int'(rx_code[0]), 'h55);
        clear_table(8'h00);
        ty[9] = 8'h30;
        start_line(8'h40, 1'b0);
        finish_line();
        check("edge16_none", rx_k, 0);

        // Every entry in zone with busy held: queue fills and scan stalls on entry 4.
        full_table();
        force_busy = 1'b1;
        start_line(8'h60, 1'b0);
        repeat (400) @(negedge clk);
        check("stall_done", int'(done), 0);
        check("stall_addr", int'(scan_addr), 9);
        check("stall_start", int'(dr_start), 0);
        force_busy = 1'b0;
        finish_line();
        check("full_first", int'(rx_code[0]), 'h40);
        check("full_last", int'(rx_code[15]), 'h4F);
        check("full_last_v", int'(rx_v[15]), 15);
        check("full_ovf", int'(ovf), 1);

        // hinit while a long draw runs and sprites are queued.
        blen = 40;
        full_table();
        start_line(8'h60, 1'b0);
        t = 0;
        while (rx_k < 1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("mid_first_req", rx_k, 1);
        repeat (40) @(negedge clk);
        clear_table(8'h00);
        ty[2] = 8'h5E; tc[2] = 8'hA2;
        ty[7] = 8'h51; tc[7] = 8'hA7;
        start_line(8'h60, 1'b0);
        finish_line();
        check("mid_code0", int'(rx_code[0]), 'hA2);
        check("mid_code1", int'(rx_code[1]), 'hA7);
        check("mid_v1", int'(rx_v[1]), 'h0F);
        blen = 2;

        // Reset in the middle of a stalled scan.
        full_table();
        force_busy = 1'b1;
        start_line(8'h60, 1'b0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        force_busy = 1'b0;
        exp_n = 0;
        exp_ovf = 0;
        line_id++;
        @(negedge clk);
        check_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_rst_no_req", rx_k, 0);
        check("post_rst_start", int'(dr_start), 0);
        check("post_rst_done", int'(done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
